// File: rtl/day_of_yr_pkg.sv
// Shared types and calendar helpers for the day-of-year counter.
// is_leap is only referenced when LEAP_YEAR_EN is defined.
package day_of_yr_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  function automatic logic is_leap(input int unsigned y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

endpackage

// File: rtl/day_of_yr_counter_if.sv
// Load channel of the day-of-year counter: valid/ready plus the date to load.
interface day_of_yr_counter_if #(
  parameter int YEAR_W = 12
);
  logic              loadValid;
  logic              loadReady;
  logic [5:0]        loadDay;
  logic [3:0]        loadMonth;
  logic [YEAR_W-1:0] loadYear;

  modport master (output loadValid, loadDay, loadMonth, loadYear, input loadReady);
  modport slave  (input loadValid, loadDay, loadMonth, loadYear, output loadReady);
endinterface

// File: rtl/day_of_yr_counter_days_in_month.sv
// Combinational month length; 0 for an out-of-range month so any day fails the range check.
// February is 29 days in leap years only when LEAP_YEAR_EN is defined.
module days_in_month
  import day_of_yr_pkg::*;
#(
  parameter int YEAR_W = 12
) (
  input  logic [3:0]        month,
  input  logic [YEAR_W-1:0] year,
  output logic [4:0]        days
);

`ifndef LEAP_YEAR_EN
  logic unused_year;
  assign unused_year = ^year;
`endif

  always_comb begin
    days = 5'd0;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = 5'd31;
      APR, JUN, SEP, NOV:                days = 5'd30;
`ifdef LEAP_YEAR_EN
      FEB: days = is_leap(32'(year)) ? 5'd29 : 5'd28;
`else
      FEB: days = 5'd28;
`endif
      default: days = 5'd0;
    endcase
  end

endmodule

// File: rtl/day_of_yr_counter.sv
// Calendar date counter with day-of-year tracking; a loaded date's day-of-year is
// rebuilt by summing month lengths in CALC. Define LEAP_YEAR_EN for Gregorian leap years.
module day_of_yr_counter
  import day_of_yr_pkg::*;
#(
  parameter int YEAR_W     = 12,
  parameter int RESET_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  day_of_yr_counter_if.slave load,
  output logic [5:0]        dayOfMonth,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [8:0]        dayOfYear,
  output logic              dateValid,
  output logic              loadErr,
  output logic              yearWrap
);

  state_t            state;
  logic [8:0]        acc;
  logic [3:0]        k;
  logic [3:0]        dim_month;
  logic [YEAR_W-1:0] dim_year;
  logic [4:0]        dim;
  logic              load_go;
  logic              load_bad;

  // A single month-length table is shared by CALC, load validation and ticking.
  always_comb begin
    dim_month = month;
    dim_year  = year;
    if (state == CALC) begin
      dim_month = k;
      dim_year  = year;
    end else if (load.loadValid) begin
      dim_month = load.loadMonth;
      dim_year  = load.loadYear;
    end
  end

  days_in_month #(.YEAR_W(YEAR_W)) u_dim (
    .month (dim_month),
    .year  (dim_year),
    .days  (dim)
  );

  assign load_go  = load.loadValid && load.loadReady;
  assign load_bad = (load.loadMonth < JAN) || (load.loadMonth > DEC) ||
                    (load.loadDay == 6'd0) || (load.loadDay > {1'b0, dim});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      dayOfMonth     <= 6'd1;
      month          <= JAN;
      year           <= YEAR_W'(RESET_YEAR);
      dayOfYear      <= 9'd1;
      dateValid      <= 1'b1;
      load.loadReady <= 1'b1;
      loadErr        <= 1'b0;
      yearWrap       <= 1'b0;
      acc            <= 9'd1;
      k              <= JAN;
    end else begin
      loadErr  <= 1'b0;
      yearWrap <= 1'b0;
      case (state)
        RUN: begin
          if (load_go) begin
            // A load, good or bad, consumes any tick on the same edge.
            if (load_bad) begin
              loadErr <= 1'b1;
            end else begin
              dayOfMonth     <= load.loadDay;
              month          <= load.loadMonth;
              year           <= load.loadYear;
              acc            <= {3'd0, load.loadDay};
              k              <= JAN;
              state          <= CALC;
              dateValid      <= 1'b0;
              load.loadReady <= 1'b0;
            end
          end else if (tick) begin
            if (dayOfMonth < {1'b0, dim}) begin
              dayOfMonth <= dayOfMonth + 6'd1;
              dayOfYear  <= dayOfYear + 9'd1;
            end else if (month < DEC) begin
              month      <= month + 4'd1;
              dayOfMonth <= 6'd1;
              dayOfYear  <= dayOfYear + 9'd1;
            end else begin
              year       <= year + YEAR_W'(1);
              month      <= JAN;
              dayOfMonth <= 6'd1;
              dayOfYear  <= 9'd1;
              yearWrap   <= 1'b1;
            end
          end
        end
        CALC: begin
          if (k == month) begin
            dayOfYear      <= acc;
            state          <= RUN;
            dateValid      <= 1'b1;
            load.loadReady <= 1'b1;
          end else begin
            acc <= acc + {4'd0, dim};
            k   <= k + 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_day_of_yr_counter.sv
// Scoreboard bench: stimulus queues expected snapshots and load completions,
// monitors pop and compare at the falling clock edge.
module tb_day_of_yr_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic tick2 = 1'b0;
  always #5 clk = ~clk;

  day_of_yr_counter_if #(.YEAR_W(12)) lb ();
  day_of_yr_counter_if #(.YEAR_W(4))  lb2 ();

  logic [5:0]  d1_day;
  logic [3:0]  d1_mon;
  logic [11:0] d1_yr;
  logic [8:0]  d1_doy;
  logic        d1_dv, d1_err, d1_wrap;
  logic [5:0]  d2_day;
  logic [3:0]  d2_mon;
  logic [3:0]  d2_yr;
  logic [8:0]  d2_doy;
  logic        d2_dv, d2_err, d2_wrap;

  day_of_yr_counter #(.YEAR_W(12), .RESET_YEAR(2000)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(lb.slave),
    .dayOfMonth(d1_day), .month(d1_mon), .year(d1_yr), .dayOfYear(d1_doy),
    .dateValid(d1_dv), .loadErr(d1_err), .yearWrap(d1_wrap)
  );

  day_of_yr_counter #(.YEAR_W(4), .RESET_YEAR(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick2), .load(lb2.slave),
    .dayOfMonth(d2_day), .month(d2_mon), .year(d2_yr), .dayOfYear(d2_doy),
    .dateValid(d2_dv), .loadErr(d2_err), .yearWrap(d2_wrap)
  );

  typedef struct {
    string nm;
    int day, mon, yr, doy, dv, lr, err, wrap;
  } snap_t;
  typedef struct { int doy; int lat; } done_t;

  snap_t snap_q[$];
  snap_t snap2_q[$];
  done_t done_q[$];
  logic  snap_req = 1'b0;
  logic  snap2_req = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cd, cm, cy, cdoy;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  task automatic cmp_snap(input snap_t e, input int day, mon, yr, doy, dv, lr, err, wrap);
    cmp({e.nm, ".day"}, day, e.day);
    cmp({e.nm, ".month"}, mon, e.mon);
    cmp({e.nm, ".year"}, yr, e.yr);
    cmp({e.nm, ".doy"}, doy, e.doy);
    cmp({e.nm, ".dateValid"}, dv, e.dv);
    cmp({e.nm, ".loadReady"}, lr, e.lr);
    cmp({e.nm, ".loadErr"}, err, e.err);
    cmp({e.nm, ".yearWrap"}, wrap, e.wrap);
  endtask

  // Monitor for the 12-bit instance.
  initial begin
    int    low_cnt;
    logic  dv_prev;
    done_t d;
    snap_t s;
    low_cnt = 0;
    dv_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_cnt = 0;
      end else begin
        if (d1_dv && !dv_prev) begin
          if (done_q.size() == 0) bad("unexpected_completion");
          else begin
            d = done_q.pop_front();
            cmp("done_doy", int'(d1_doy), d.doy);
            cmp("calc_cycles", low_cnt, d.lat);
          end
          low_cnt = 0;
        end
        if (!d1_dv) begin
          low_cnt++;
          cmp("ready_in_calc", int'(lb.loadReady), 0);
        end
        if (d1_err && !snap_req)  bad("unexpected_loadErr");
        if (d1_wrap && !snap_req) bad("unexpected_yearWrap");
      end
      dv_prev = d1_dv;
      if (snap_req) begin
        if (snap_q.size() == 0) bad("snap_underflow");
        else begin
          s = snap_q.pop_front();
          cmp_snap(s, d1_day, d1_mon, d1_yr, d1_doy, d1_dv, lb.loadReady, d1_err, d1_wrap);
        end
      end
    end
  end

  // Monitor for the 4-bit year instance.
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (snap2_req) begin
        if (snap2_q.size() == 0) bad("snap2_underflow");
        else begin
          s = snap2_q.pop_front();
          cmp_snap(s, d2_day, d2_mon, d2_yr, d2_doy, d2_dv, lb2.loadReady, d2_err, d2_wrap);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap(input string nm, input int day, mon, yr, doy, dv, lr, err, wrap);
    snap_q.push_back('{nm, day, mon, yr, doy, dv, lr, err, wrap});
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic snap2(input string nm, input int day, mon, yr, doy, dv, lr, err, wrap);
    snap2_q.push_back('{nm, day, mon, yr, doy, dv, lr, err, wrap});
    snap2_req = 1'b1;
    step();
    snap2_req = 1'b0;
  endtask

  task automatic set_load(input int d, m, y);
    lb.loadDay   = 6'(d);
    lb.loadMonth = 4'(m);
    lb.loadYear  = 12'(y);
    lb.loadValid = 1'b1;
  endtask

  task automatic clr_load();
    lb.loadValid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (!d1_dv && t < 40) begin
      step();
      t++;
    end
    if (!d1_dv) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got dateValid 0, expected 1 within 40 cycles", nm);
    end
  endtask

  // Valid load: queue completion, accept, wait, then confirm the registered date.
  task automatic good_load(input string nm, input int d, m, y, doy);
    set_load(d, m, y);
    done_q.push_back('{doy, m});
    step();
    clr_load();
    wait_done(nm);
    cd = d; cm = m; cy = y; cdoy = doy;
    snap(nm, cd, cm, cy, cdoy, 1, 1, 0, 0);
  endtask

  task automatic err_load(input string nm, input int d, m, y);
    set_load(d, m, y);
    snap(nm, cd, cm, cy, cdoy, 1, 1, 1, 0);
    clr_load();
    snap({nm, "_after"}, cd, cm, cy, cdoy, 1, 1, 0, 0);
  endtask

  initial begin
    int t;
    lb.loadValid = 1'b0;  lb.loadDay = '0;  lb.loadMonth = '0;  lb.loadYear = '0;
    lb2.loadValid = 1'b0; lb2.loadDay = '0; lb2.loadMonth = '0; lb2.loadYear = '0;
    cd = 1; cm = 1; cy = 2000; cdoy = 1;

    step();
    snap("in_reset", 1, 1, 2000, 1, 1, 1, 0, 0);
    rst_n = 1'b1;
    snap("reset", 1, 1, 2000, 1, 1, 1, 0, 0);

    tick = 1'b1;
    repeat (31) step();
    tick = 1'b0;
    cd = 1; cm = 2; cdoy = 32;
    snap("ticks31", 1, 2, 2000, 32, 1, 1, 0, 0);

    good_load("dec31", 31, 12, 2023, 365);
    tick = 1'b1;
    cd = 1; cm = 1; cy = 2024; cdoy = 1;
    snap("wrap", 1, 1, 2024, 1, 1, 1, 0, 1);
    tick = 1'b0;
    snap("wrap_end", 1, 1, 2024, 1, 1, 1, 0, 0);

`ifdef LEAP_YEAR_EN
    good_load("feb29_2024", 29, 2, 2024, 60);
`else
    err_load("feb29_2024", 29, 2, 2024);
`endif
    err_load("feb29_1900", 29, 2, 1900);
    err_load("month13", 1, 13, 2020);
    err_load("month0", 1, 0, 2020);
    err_load("day0", 0, 5, 2020);
    err_load("apr31", 31, 4, 2022);

    // Tick on the accept edge and throughout CALC must all be dropped.
    tick = 1'b1;
    set_load(15, 3, 2021);
    done_q.push_back('{74, 3});
    step();
    clr_load();
    wait_done("mar15");
    tick = 1'b0;
    cd = 15; cm = 3; cy = 2021; cdoy = 74;
    snap("mar15", 15, 3, 2021, 74, 1, 1, 0, 0);

    good_load("feb28", 28, 2, 2023, 59);
    tick = 1'b1;
    snap("feb_end_tick", 1, 3, 2023, 60, 1, 1, 0, 0);
    tick = 1'b0;
    good_load("jan31", 31, 1, 2022, 31);

    // Reset in the middle of CALC.
    set_load(1, 12, 2000);
    step();
    clr_load();
    snap("mid_calc", 1, 12, 2000, 31, 0, 0, 0, 0);
    step(); step(); step();
    rst_n = 1'b0;
    snap("calc_reset", 1, 1, 2000, 1, 1, 1, 0, 0);
    rst_n = 1'b1;
    snap("calc_reset_after", 1, 1, 2000, 1, 1, 1, 0, 0);

    // 4-bit year instance: wrap 15 -> 0.
    lb2.loadDay = 6'd31; lb2.loadMonth = 4'd12; lb2.loadYear = 4'd15; lb2.loadValid = 1'b1;
    step();
    lb2.loadValid = 1'b0;
    t = 0;
    while (!d2_dv && t < 40) begin
      step();
      t++;
    end
    cmp("y4_latency", t, 12);
    snap2("y4_dec31", 31, 12, 15, 365, 1, 1, 0, 0);
    tick2 = 1'b1;
    snap2("y4_wrap", 1, 1, 0, 1, 1, 1, 0, 1);
    tick2 = 1'b0;
    snap2("y4_wrap_end", 1, 1, 0, 1, 1, 1, 0, 0);

    step();
    cmp("snap_q_drained", snap_q.size(), 0);
    cmp("done_q_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/day_of_yr_counter.md
DAY_OF_YR_COUNTER -- requirements
Module: day_of_yr_counter

Interface
REQ-001 Parameter YEAR_W, default 12, year register width (years 0..2^YEAR_W-1) SHALL be supported.
REQ-002 Parameter RESET_YEAR, default 2000, year loaded at reset, SHALL be supported.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  advance date by one day.
REQ-006 loadValid  input  1  load request.
REQ-007 loadReady  output  1  load can be accepted.
REQ-008 loadDay  input  6  day to load, 1..31.
REQ-009 loadMonth  input  4  month to load, 1..12.
REQ-010 loadYear  input  YEAR_W  year to load.
REQ-011 dayOfMonth  output  6  current day.
REQ-012 month  output  4  current month.
REQ-013 year  output  YEAR_W  current year.
REQ-014 dayOfYear  output  9  current day of year, 1..366.
REQ-015 dateValid  output  1  outputs coherent.
REQ-016 loadErr  output  1  one-cycle pulse, load rejected.
REQ-017 yearWrap  output  1  one-cycle pulse, 31-Dec to 01-Jan rollover.

Function
REQ-018 FSM states SHALL be RUN and CALC; all outputs SHALL be registered.
REQ-019 loadReady SHALL be 1 exactly in RUN; dateValid SHALL be 0 exactly in CALC.
REQ-020 Load is accepted on an edge with loadValid && loadReady; an accepted load SHALL win over a simultaneous tick, and that tick SHALL be dropped.
REQ-021 Accepted load with loadMonth outside 1..12 or loadDay outside 1..daysInMonth(loadMonth, loadYear) SHALL assert loadErr for the next cycle, leave all date outputs unchanged, and stay in RUN.
REQ-022 Valid load SHALL register the date, set accumulator = loadDay, set k = 1, and enter CALC.
REQ-023 Each CALC edge: if k == month, dayOfYear <= accumulator, go to RUN, dateValid <= 1; else accumulator += daysInMonth(k, year) and k++.
REQ-024 CALC therefore lasts exactly loadMonth cycles: dateValid SHALL return high loadMonth edges after the accept edge.
REQ-025 tick in CALC SHALL be ignored.
REQ-026 tick in RUN: if day < daysInMonth then day++ and dayOfYear++.
REQ-027 tick in RUN at month end with month < 12: month++, day = 1, dayOfYear++.
REQ-028 tick in RUN at 31-Dec: year++ (modulo 2^YEAR_W), month = 1, day = 1, dayOfYear = 1, and yearWrap pulses for one cycle.
REQ-029 Arithmetic SHALL be unsigned; the accumulator SHALL be 9 bits and SHALL never exceed 366.

Reset
REQ-030 rst_n low SHALL immediately force state RUN, date 01-Jan-RESET_YEAR, dayOfYear 1, dateValid 1, loadReady 1, loadErr 0, yearWrap 0, including when asserted mid-CALC.

Configuration
REQ-031 With LEAP_YEAR_EN defined, a year SHALL be leap when (y%4==0 && y%100!=0) || y%400==0, and February SHALL then have 29 days.
REQ-032 Without LEAP_YEAR_EN, February SHALL always have 28 days, and 29-Feb loads SHALL raise loadErr.

Structure
REQ-033 Package day_of_yr_pkg SHALL hold the state enum, the month constants JAN..DEC, and the is_leap function.
REQ-034 Sub-module days_in_month (inputs month and year, output 5-bit day count) SHALL be combinational and instantiated once.
REQ-035 The days_in_month month/year input mux SHALL select: CALC -> k/year; RUN with loadValid -> loadMonth/loadYear; otherwise -> current month/year.

Verification
REQ-036 Reset then 31 ticks -> 01-Feb-2000, dayOfYear 32, dateValid 1.
REQ-037 Load 31-Dec-2023 -> loadReady 0 for 12 cycles, then dayOfYear 365; 1 tick -> 01-Jan-2024, dayOfYear 1, yearWrap pulse.
REQ-038 Load 29-Feb-2024 with LEAP_YEAR_EN -> dayOfYear 60; load 29-Feb-1900 -> loadErr pulse, date unchanged.
REQ-039 Load 15-Mar-2021 with tick on the same edge and ticks during CALC -> dayOfYear 74, ticks dropped.
REQ-040 Load 01-Dec-2000, then assert rst_n low at CALC cycle 5 -> 01-Jan-2000, dayOfYear 1, RUN.
REQ-041 YEAR_W=4, load 31-Dec-15, 1 tick -> year 0, yearWrap pulse.
